scfifo_wr_arbiter: RTL and testbench

- Packet-aware round-robin arbiter that shares the single write port of one scfifo_ver instance among NUM_REQ requesters.
- Each requester presents valid/ready/data/eop. A grant is held from the first beat to the eop beat, so packets never interleave in the FIFO.
- The write port is registered, with one cycle of latency. Admission is computed from the FIFO's usedw/full so the FIFO is never overflowed.
- Sits directly in front of scfifo_ver; its fifo_* ports connect to the FIFO's data/wrreq/usedw/full.

---
 rtl/scfifo_wr_arbiter_if.sv | 40 ++++
 rtl/scfifo_wr_arbiter.sv | 154 +++++++++++++++
 tb/tb_scfifo_wr_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/scfifo_wr_arbiter_if.sv
// Bundles the requester-side and FIFO-side write signals of the packet-aware
// round-robin write arbiter that sits in front of one scfifo_ver instance.
//
// Signals:
//   req_valid / req_eop / req_data  - per-requester beat, last-beat flag, payload
//   req_ready                       - per-requester beat accepted this cycle
//   fifo_wrreq / fifo_data          - registered write strobe and {eop, src_id, payload}
//   fifo_usedw / fifo_full          - fill status coming back from the FIFO
//   grant_id / busy                 - current/last granted requester, packet lock flag
//
// Modports:
//   master - the arbiter itself
//   slave  - the surrounding system (requesters plus FIFO)
interface scfifo_wr_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_WIDTHU = 4,
    parameter int IDW         = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_eop;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_wrreq;
    logic [DATA_WIDTH+IDW:0]       fifo_data;
    logic [FIFO_WIDTHU-1:0]        fifo_usedw;
    logic                          fifo_full;
    logic [IDW-1:0]                grant_id;
    logic                          busy;

    modport master (
        input  req_valid, req_eop, req_data, fifo_usedw, fifo_full,
        output req_ready, fifo_wrreq, fifo_data, grant_id, busy
    );

    modport slave (
        output req_valid, req_eop, req_data, fifo_usedw, fifo_full,
        input  req_ready, fifo_wrreq, fifo_data, grant_id, busy
    );
endinterface

// File: rtl/scfifo_wr_arbiter.sv
// Packet-aware round-robin arbiter sharing the single write port of one
// scfifo_ver among NUM_REQ requesters. A grant is held from the first beat of a
// packet to its eop beat so packets never interleave inside the FIFO. The write
// port is registered (one cycle from handshake to write), and admission is
// derived from usedw/full plus the beat still in flight, so the FIFO can never
// be overflowed.
//
// Ports:
//   clock_i  - system clock, rising edge
//   aclr_n_i - asynchronous active-low reset
//   sclr_i   - synchronous active-high clear, same effect as reset
//   bus      - scfifo_wr_arbiter_if master modport (requesters + FIFO write side)
module scfifo_wr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int FIFO_WIDTHU = 4,
    parameter int IDW         = $clog2(NUM_REQ)
) (
    input  logic                  clock_i,
    input  logic                  aclr_n_i,
    input  logic                  sclr_i,
    scfifo_wr_arbiter_if.master   bus
);

    localparam int                 FW      = DATA_WIDTH + 1 + IDW;
    localparam logic [FIFO_WIDTHU:0] DEPTH_W = (FIFO_WIDTHU+1)'(FIFO_DEPTH);
    localparam logic [IDW-1:0]     LAST_ID = IDW'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rrPtr_q, rrPtr_d;
    logic [IDW-1:0]  lockId_q, lockId_d;
    logic [IDW-1:0]  grantId_q, grantId_d;
    logic            busy_q, busy_d;
    logic            wrreq_q, wrreq_d;
    logic [FW-1:0]   data_q, data_d;

    logic [IDW-1:0]         winner;
    logic                   haveWinner;
    logic                   winEop;
    logic [DATA_WIDTH-1:0]  winData;
    logic [FIFO_WIDTHU:0]   usedPlusFlight;
    logic                   space;
    logic                   transfer;

    // Room check: the beat sitting in the output register has not reached
    // usedw yet, so it is counted here. A simultaneous FIFO read is ignored,
    // which only ever makes admission more cautious.
    always_comb begin
        usedPlusFlight = {1'b0, bus.fifo_usedw} + {{FIFO_WIDTHU{1'b0}}, wrreq_q};
        space          = ~bus.fifo_full & (usedPlusFlight < DEPTH_W);
    end

    // Winner selection. While a packet is open the owner keeps the port no
    // matter who else is asking. Otherwise scan upward from the round-robin
    // pointer; the scan runs backwards so the closest valid requester is the
    // last one written and therefore wins.
    always_comb begin
        winner     = '0;
        haveWinner = 1'b0;
        if (state_q == LOCKED) begin
            winner     = lockId_q;
            haveWinner = 1'b1;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (bus.req_valid[(int'(rrPtr_q) + k) % NUM_REQ]) begin
                    winner     = IDW'((int'(rrPtr_q) + k) % NUM_REQ);
                    haveWinner = 1'b1;
                end
            end
        end
        winEop  = bus.req_eop[winner];
        winData = bus.req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Only the winner can ever see ready. Ready is forced low while either
    // reset is active so no beat is lost into a register that is being cleared.
    always_comb begin
        transfer      = haveWinner & space & bus.req_valid[winner] & aclr_n_i & ~sclr_i;
        bus.req_ready = '0;
        if (transfer) begin
            bus.req_ready[winner] = 1'b1;
        end
    end

    // Next-state logic for the arbitration FSM and the output register. A
    // packet that finishes rotates priority to just past its owner, which makes
    // the most recent winner the lowest priority. Single-beat packets never
    // lock the port.
    always_comb begin
        state_d   = state_q;
        rrPtr_d   = rrPtr_q;
        lockId_d  = lockId_q;
        grantId_d = grantId_q;
        busy_d    = busy_q;
        wrreq_d   = 1'b0;
        data_d    = data_q;
        if (transfer) begin
            wrreq_d   = 1'b1;
            data_d    = {winEop, winner, winData};
            grantId_d = winner;
            if (winEop) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                rrPtr_d = (winner == LAST_ID) ? '0 : winner + 1'b1;
            end else begin
                state_d  = LOCKED;
                busy_d   = 1'b1;
                lockId_d = winner;
            end
        end
    end

    // All state lives here. The synchronous clear behaves exactly like the
    // asynchronous reset and overrides any handshake in the same cycle.
    always_ff @(posedge clock_i or negedge aclr_n_i) begin
        if (!aclr_n_i) begin
            state_q   <= IDLE;
            rrPtr_q   <= '0;
            lockId_q  <= '0;
            grantId_q <= '0;
            busy_q    <= 1'b0;
            wrreq_q   <= 1'b0;
            data_q    <= '0;
        end else if (sclr_i) begin
            state_q   <= IDLE;
            rrPtr_q   <= '0;
            lockId_q  <= '0;
            grantId_q <= '0;
            busy_q    <= 1'b0;
            wrreq_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            rrPtr_q   <= rrPtr_d;
            lockId_q  <= lockId_d;
            grantId_q <= grantId_d;
            busy_q    <= busy_d;
            wrreq_q   <= wrreq_d;
            data_q    <= data_d;
        end
    end

    assign bus.fifo_wrreq = wrreq_q;
    assign bus.fifo_data  = data_q;
    assign bus.grant_id   = grantId_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_scfifo_wr_arbiter.sv
// Self-checking bench for scfifo_wr_arbiter. The bench plays both the
// requesters and the attached FIFO (an occupancy counter), and keeps a
// packet-level reference model: an owner id (or -1 when nobody holds the
// port) and the requester that currently has top priority.
module tb_scfifo_wr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int WU    = 4;
    localparam int IDW   = 2;

    logic clock;
    logic aclrN;
    logic sclr;

    scfifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .FIFO_WIDTHU(WU)) bus ();

    scfifo_wr_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FIFO_WIDTHU(WU)
    ) dut (
        .clock_i (clock),
        .aclr_n_i(aclrN),
        .sclr_i  (sclr),
        .bus     (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;

    // Reference model state.
    int               owner;
    int               prio;
    bit               expWr;
    logic [DW+IDW:0]  expData;
    logic [IDW-1:0]   expGrant;
    bit               expBusy;
    logic [N-1:0]     mReady;
    int               fifoCnt;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        owner    = -1;
        prio     = 0;
        expWr    = 1'b0;
        expData  = '0;
        expGrant = '0;
        expBusy  = 1'b0;
    endtask

    task automatic driveFifoStatus();
        bus.fifo_usedw = WU'(fifoCnt);
        bus.fifo_full  = (fifoCnt >= DEPTH);
    endtask

    // One clock cycle: check registered outputs, drive the requesters, check
    // ready against the model, advance the model, then let the FIFO absorb the
    // write/read that happen on the edge.
    task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] e,
                                 input logic [N*DW-1:0] d, input bit rd, input bit clr);
        int  win;
        bit  have;
        bit  roomM;
        bit  xfer;
        bit  wrNow;
        @(negedge clock);
        checkOutput("wrreq", bus.fifo_wrreq, expWr);
        checkOutput("data",  bus.fifo_data,  expData);
        checkOutput("grant", bus.grant_id,   expGrant);
        checkOutput("busy",  bus.busy,       expBusy);
        bus.req_valid = v;
        bus.req_eop   = e;
        bus.req_data  = d;
        sclr          = clr;
        have = 1'b0;
        win  = 0;
        if (owner >= 0) begin
            win  = owner;
            have = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!have && v[(prio + k) % N]) begin
                    win  = (prio + k) % N;
                    have = 1'b1;
                end
            end
        end
        roomM  = (fifoCnt + int'(expWr)) < DEPTH;
        xfer   = !clr && have && roomM && v[win];
        mReady = xfer ? (N'(1) << win) : '0;
        #1;
        checkOutput("ready", bus.req_ready, mReady);
        wrNow = bus.fifo_wrreq;
        if (clr) begin
            resetModel();
        end else if (xfer) begin
            expWr    = 1'b1;
            expData  = {e[win], IDW'(win), d[win*DW +: DW]};
            expGrant = IDW'(win);
            if (e[win]) begin
                owner = -1;
                prio  = (win + 1) % N;
            end else begin
                owner = win;
            end
            expBusy = (owner >= 0);
        end else begin
            expWr = 1'b0;
        end
        @(posedge clock);
        #1;
        if (wrNow) begin
            checkOutput("noOverflow", fifoCnt < DEPTH, 1);
        end
        fifoCnt = fifoCnt + ((wrNow && fifoCnt < DEPTH) ? 1 : 0) - ((rd && fifoCnt > 0) ? 1 : 0);
        driveFifoStatus();
    endtask

    // Asynchronous reset pulse asserted between clock edges.
    task automatic asyncReset();
        aclrN = 1'b0;
        #1;
        checkOutput("rstBusy",  bus.busy,       0);
        checkOutput("rstWrreq", bus.fifo_wrreq, 0);
        checkOutput("rstReady", bus.req_ready,  0);
        checkOutput("rstGrant", bus.grant_id,   0);
        checkOutput("rstData",  bus.fifo_data,  0);
        resetModel();
        @(posedge clock);
        #1;
        aclrN = 1'b1;
    endtask

    // Random requester state, held until the model says the beat was taken.
    logic [N-1:0]    rv, re;
    logic [N*DW-1:0] rdat;
    int              wrCount;

    initial begin
        aclrN          = 1'b0;
        sclr           = 1'b0;
        bus.req_valid  = '0;
        bus.req_eop    = '0;
        bus.req_data   = '0;
        fifoCnt        = 0;
        mReady         = '0;
        driveFifoStatus();
        resetModel();

        // Power-on reset.
        #1;
        checkOutput("rstBusy",  bus.busy,       0);
        checkOutput("rstWrreq", bus.fifo_wrreq, 0);
        checkOutput("rstData",  bus.fifo_data,  0);
        checkOutput("rstGrant", bus.grant_id,   0);
        @(posedge clock);
        #1;
        aclrN = 1'b1;

        // Single requester, single-beat packet.
        applyStimulus(4'b0001, 4'b0001, 32'h0000_00A5, 1'b0, 1'b0);
        checkOutput("a5Wrreq", bus.fifo_wrreq, 1);
        checkOutput("a5Data",  bus.fifo_data,  11'h4A5);
        for (int i = 0; i < 20; i++) applyStimulus('0, '0, '0, 1'b1, 1'b0);

        // Full boundary: stream from req0 with no reads.
        wrCount = 0;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(4'b0001, 4'b0001, 32'h0000_003C, 1'b0, 1'b0);
            wrCount += int'(bus.fifo_wrreq);
        end
        checkOutput("fullWrites", wrCount, 16);
        checkOutput("fullFlag",   bus.fifo_full, 1);
        wrCount = 0;
        applyStimulus(4'b0001, 4'b0001, 32'h0000_003C, 1'b1, 1'b0);
        wrCount += int'(bus.fifo_wrreq);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'b0001, 4'b0001, 32'h0000_003C, 1'b0, 1'b0);
            wrCount += int'(bus.fifo_wrreq);
        end
        checkOutput("oneMore", wrCount, 1);
        for (int i = 0; i < 20; i++) applyStimulus('0, '0, '0, 1'b1, 1'b0);

        // Lock with a gap: req2 opens a packet, stalls, then finishes it.
        applyStimulus(4'b0100, 4'b0000, 32'h0011_2233, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(4'b1011, 4'b1011, 32'h4455_6677, 1'b1, 1'b0);
        checkOutput("gapBusy", bus.busy, 1);
        applyStimulus(4'b1111, 4'b1011, 32'h8899_AABB, 1'b1, 1'b0);
        applyStimulus(4'b1111, 4'b1111, 32'h8899_AABB, 1'b1, 1'b0);
        checkOutput("gapGrant", bus.grant_id, 2);

        // Reset in the middle of a locked packet, then round-robin from 0.
        applyStimulus(4'b0010, 4'b0000, 32'h0000_5A00, 1'b1, 1'b0);
        asyncReset();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1111, 4'b1111, 32'hD3C2_B1A0 + 32'(k), 1'b1, 1'b0);
            checkOutput("rrWrreq", bus.fifo_wrreq, 1);
            checkOutput("rrSrc",   bus.fifo_data[DW +: IDW], k % N);
        end

        // Randomised traffic with multi-beat packets, gaps and occasional sclr.
        rv   = '0;
        re   = '0;
        rdat = '0;
        for (int c = 0; c < 800; c++) begin
            bit rdEn;
            bit clr;
            rdEn = (c < 400) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            clr  = ($urandom_range(0, 119) == 0);
            applyStimulus(rv, re, rdat, rdEn, clr);
            for (int i = 0; i < N; i++) begin
                if (rv[i] && mReady[i]) begin
                    rv[i]            = ($urandom_range(0, 3) != 0);
                    re[i]            = ($urandom_range(0, 2) == 0);
                    rdat[i*DW +: DW] = DW'($urandom);
                end else if (!rv[i]) begin
                    rv[i]            = ($urandom_range(0, 3) == 0);
                    re[i]            = ($urandom_range(0, 2) == 0);
                    rdat[i*DW +: DW] = DW'($urandom);
                end
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
